// File: rtl/branch_pc_controller.sv
// Branch PC-select controller: 2-bit counter BHT predicts conditional branches
// at decode; a FIFO of in-flight predictions is checked against execute to raise redirects.
module branch_pc_controller #(
    parameter int BHT_IDX_BITS = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic              dec_is_branch,
    input  logic              dec_is_jump,
    input  logic [31:0]       dec_pc,
    output logic [1:0]        PCSrc,
    output logic              prediction,
    output logic              stall,
    input  logic              ex_resolve,
    input  logic              ex_taken,
    input  logic [31:0]       ex_pc,
    input  logic [31:0]       ex_imm,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              flush,
    output logic [CNT_W-1:0]  pending_count,
    output logic              err_underflow,
    output logic              dbg_state_o
);

    typedef enum logic {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              bht_q [2**BHT_IDX_BITS];
    logic                    fifo_pred_q [FIFO_DEPTH];
    logic [BHT_IDX_BITS-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    err_q;

    logic [BHT_IDX_BITS-1:0] dec_idx, head_idx;
    logic                    run, cond_br, fifo_full, fifo_empty;
    logic                    resolve_ok, head_pred, mispredict, push, pop;
    logic [1:0]              bht_upd;
    logic                    unused_pc_bits;

    assign dec_idx        = dec_pc[BHT_IDX_BITS+1:2];
    assign unused_pc_bits = ^{dec_pc[31:BHT_IDX_BITS+2], dec_pc[1:0]};
    assign run            = (state_q == ST_RUN);
    assign cond_br        = dec_valid & dec_is_branch & ~dec_is_jump;
    assign fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty     = (count_q == '0);
    assign resolve_ok     = ex_resolve & ~fifo_empty;
    assign head_pred      = fifo_pred_q[head_q];
    assign head_idx       = fifo_idx_q[head_q];
    assign mispredict     = resolve_ok & (head_pred != ex_taken);
    assign pop            = resolve_ok;
    // A same-cycle pop frees the slot the push would need, so full alone does not block it.
    assign push           = run & cond_br & (~fifo_full | resolve_ok) & ~mispredict;

    assign stall          = run & cond_br & fifo_full & ~ex_resolve;
    assign redirect_valid = mispredict;
    assign flush          = mispredict;
    assign redirect_pc    = mispredict ? (ex_taken ? ex_pc + ex_imm : ex_pc + 32'd4) : 32'd0;
    assign pending_count  = count_q;
    assign err_underflow  = err_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        PCSrc      = 2'b00;
        prediction = 1'b0;
        if (run && dec_valid) begin
            if (dec_is_jump) begin
                PCSrc = 2'b01;
            end else if (dec_is_branch) begin
                PCSrc      = 2'b10;
                prediction = bht_q[dec_idx][1];
            end
        end
    end

    always_comb begin
        bht_upd = bht_q[head_idx];
        if (ex_taken) begin
            if (bht_q[head_idx] != 2'b11) bht_upd = bht_q[head_idx] + 2'b01;
        end else begin
            if (bht_q[head_idx] != 2'b00) bht_upd = bht_q[head_idx] - 2'b01;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = (run && mispredict) ? ST_RECOVER : ST_RUN;
        if (mispredict) begin
            // Every younger branch in the FIFO is on the squashed path.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**BHT_IDX_BITS; i++) bht_q[i] <= 2'b01;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            if (pop) bht_q[head_idx] <= bht_upd;
            if (ex_resolve && fifo_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pred_q[tail_q] <= prediction;
            fifo_idx_q[tail_q]  <= dec_idx;
        end
    end

endmodule

// File: tb/tb_branch_pc_controller.sv
// Directed bench for branch_pc_controller: the driver queues hand-computed
// expected outputs, a negedge monitor pops and compares them.
module tb_branch_pc_controller;

    localparam int W = 43;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_is_branch, dec_is_jump;
    logic [31:0] dec_pc;
    logic [1:0]  PCSrc;
    logic        prediction, stall;
    logic        ex_resolve, ex_taken;
    logic [31:0] ex_pc, ex_imm;
    logic        redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic [2:0]  pending_count;
    logic        err_underflow;
    logic        dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run = 0;
    int           tests_failed = 0;

    branch_pc_controller #(.BHT_IDX_BITS(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_is_branch(dec_is_branch), .dec_is_jump(dec_is_jump),
        .dec_pc(dec_pc), .PCSrc(PCSrc), .prediction(prediction), .stall(stall),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .pending_count(pending_count), .err_underflow(err_underflow), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; each expected vector holds
    // that cycle's combinational outputs plus the registered state before the next edge.
    task automatic step(input string nm, input logic v, input logic br, input logic jp,
                        input logic [31:0] pc, input logic res, input logic tk,
                        input logic [31:0] epc, input logic [31:0] eimm,
                        input logic [1:0] e_src, input logic e_pred, input logic e_stall,
                        input logic e_rv, input logic [31:0] e_rpc, input logic [2:0] e_cnt,
                        input logic e_err, input logic e_st);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        dec_valid     = v;
        dec_is_branch = br;
        dec_is_jump   = jp;
        dec_pc        = pc;
        ex_resolve    = res;
        ex_taken      = tk;
        ex_pc         = epc;
        ex_imm        = eimm;
        exp_q.push_back({e_src, e_pred, e_stall, e_rv, e_rv, e_rpc, e_cnt, e_err, e_st});
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        dec_valid     = 1'b0;
        dec_is_branch = 1'b0;
        dec_is_jump   = 1'b0;
        ex_resolve    = 1'b0;
    endtask

    logic [W-1:0] mon_got, mon_exp;
    string        mon_name;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {PCSrc, prediction, stall, redirect_valid, flush, redirect_pc,
                        pending_count, err_underflow, dbg_state};
            tests_run++;
            if (mon_got !== mon_exp) begin
                tests_failed++;
                $display("FAIL %s: got src=%b pred=%b stall=%b rv=%b fl=%b rpc=%h cnt=%0d err=%b st=%b, exp src=%b pred=%b stall=%b rv=%b fl=%b rpc=%h cnt=%0d err=%b st=%b",
                         mon_name, mon_got[42:41], mon_got[40], mon_got[39], mon_got[38], mon_got[37],
                         mon_got[36:5], mon_got[4:2], mon_got[1], mon_got[0],
                         mon_exp[42:41], mon_exp[40], mon_exp[39], mon_exp[38], mon_exp[37],
                         mon_exp[36:5], mon_exp[4:2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dec_valid = 1'b0; dec_is_branch = 1'b0; dec_is_jump = 1'b0;
        dec_pc = '0; ex_resolve = 1'b0; ex_taken = 1'b0; ex_pc = '0; ex_imm = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First branch, weakly-not-taken, then taken mispredict; BHT[0] -> 10
        step("br40_predict",       1,1,0,32'h40, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd0,0,0);
        step("res40_taken_mp",     0,0,0,32'h0,  1,1,32'h40,32'h20,        2'b00,0,0,1,32'h60, 3'd1,0,0);
        step("recover_blocks_br",  1,1,0,32'h40, 0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,0,1);
        step("br40_pred_taken",    1,1,0,32'h40, 0,0,32'h0,32'h0,          2'b10,1,0,0,32'h0,  3'd0,0,0);
        step("res40_nt_mp",        0,0,0,32'h0,  1,0,32'h40,32'h20,        2'b00,0,0,1,32'h44, 3'd1,0,0);
        step("recover_idle",       0,0,0,32'h0,  0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,0,1);
        // Fill the FIFO, stall when full, then pop+push in one cycle
        step("br40_weak_again",    1,1,0,32'h40, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd0,0,0);
        step("fill_br44",          1,1,0,32'h44, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd1,0,0);
        step("fill_br48",          1,1,0,32'h48, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd2,0,0);
        step("fill_br4c",          1,1,0,32'h4c, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd3,0,0);
        step("stall_full",         1,1,0,32'h50, 0,0,32'h0,32'h0,          2'b10,0,1,0,32'h0,  3'd4,0,0);
        step("full_pop_push",      1,1,0,32'h50, 1,0,32'h40,32'h100,       2'b10,0,0,0,32'h0,  3'd4,0,0);
        // Mispredict with a branch at decode: push dropped, FIFO cleared, target wraps
        step("mp_drops_push_wrap", 1,1,0,32'h54, 1,1,32'hFFFFFFF8,32'h10,  2'b10,0,0,1,32'h8,  3'd4,0,0);
        step("recover_forces_seq", 1,1,0,32'h54, 0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,0,1);
        step("br44_pred_taken",    1,1,0,32'h44, 0,0,32'h0,32'h0,          2'b10,1,0,0,32'h0,  3'd0,0,0);
        // Decode priority and non-pushing cases
        step("jump_priority",      1,1,1,32'h48, 0,0,32'h0,32'h0,          2'b01,0,0,0,32'h0,  3'd1,0,0);
        step("jump_only",          1,0,1,32'h48, 0,0,32'h0,32'h0,          2'b01,0,0,0,32'h0,  3'd1,0,0);
        step("plain_instr",        1,0,0,32'h48, 0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd1,0,0);
        step("invalid_branch",     0,1,0,32'h48, 0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd1,0,0);
        step("res44_correct",      0,0,0,32'h0,  1,1,32'h44,32'h8,         2'b00,0,0,0,32'h0,  3'd1,0,0);
        step("underflow",          0,0,0,32'h0,  1,1,32'h44,32'h8,         2'b00,0,0,0,32'h0,  3'd0,0,0);
        step("err_sticky",         0,0,0,32'h0,  0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,1,0);
        // Index 3: read-before-update hazard and saturation at 11
        step("br4c_weak",          1,1,0,32'h4c, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd0,1,0);
        step("hazard_mp_4c",       1,1,0,32'h4c, 1,1,32'h4c,32'h4,         2'b10,0,0,1,32'h50, 3'd1,1,0);
        step("recover_4c",         0,0,0,32'h0,  0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,1,1);
        step("br4c_pred_taken",    1,1,0,32'h4c, 0,0,32'h0,32'h0,          2'b10,1,0,0,32'h0,  3'd0,1,0);
        step("hazard_ok_4c",       1,1,0,32'h4c, 1,1,32'h4c,32'h4,         2'b10,1,0,0,32'h0,  3'd1,1,0);
        step("sat_taken_4c",       1,1,0,32'h4c, 1,1,32'h4c,32'h4,         2'b10,1,0,0,32'h0,  3'd1,1,0);
        step("sat_mp_4c",          1,0,0,32'h4c, 1,0,32'h4c,32'h4,         2'b00,0,0,1,32'h50, 3'd1,1,0);
        step("recover_sat",        0,0,0,32'h0,  0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd0,1,1);
        step("sat_no_wrap",        1,1,0,32'h4c, 0,0,32'h0,32'h0,          2'b10,1,0,0,32'h0,  3'd0,1,0);
        step("br50_mid",           1,1,0,32'h50, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd1,1,0);
        // Reset mid-stream clears FIFO, counters and sticky error
        do_reset();
        step("post_reset_bht",     1,1,0,32'h4c, 0,0,32'h0,32'h0,          2'b10,0,0,0,32'h0,  3'd0,0,0);
        step("post_reset_cnt",     0,0,0,32'h0,  0,0,32'h0,32'h0,          2'b00,0,0,0,32'h0,  3'd1,0,0);

        repeat (3) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
